axi_comm_slave: RTL and testbench
=================================

Name: axi_comm_slave

Overview:
AXI4-Lite slave register block: a bank of 32-bit read/write registers on the system AXI bus. Independent write (AW/W/B) and read (AR/R) paths, one outstanding transaction per path. Used as the shared mailbox/config space between bus masters and local logic.

Parameters:
ADDR_WIDTH, 32, AWADDR/ARADDR width.
DATA_WIDTH, 32, data width; fixed at 32 (WSTRB is 4 bits).
NUM_REGS, 16, number of registers; power of 2, at least 2; word-addressed at byte offsets 0x00, 0x04, ...

Ports:
ACLK  in  1  bus clock; all logic on rising edge.
ARESET  in  1  reset, synchronous, active-high.
AWADDR  in  ADDR_WIDTH  write address.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
WDATA  in  32  write data.
WSTRB  in  4  byte enables; bit i enables WDATA[8i+7:8i].
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
BRESP  out  2  write response.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
ARADDR  in  ADDR_WIDTH  read address.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
RDATA  out  32  read data.
RRESP  out  2  read response.
RVALID  out  1  read data valid.
RREADY  in  1  read data ready.

Behaviour:
- Reset (ARESET=1 at a clock edge): all registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP = 0; RDATA = 0. Any in-flight transaction is dropped. After reset the ready outputs go high on the first clock edge with ARESET=0.
- Register index = addr[log2(NUM_REGS)+1:2]. addr[1:0] is ignored.
- An address is in range when addr < NUM_REGS*4. Upper address bits must be zero.
- All outputs are registered.
- A handshake occurs on any edge where VALID and READY are both 1.
- Write path:
  - AWREADY=1 while no AW beat is held and BVALID=0.
  - WREADY=1 while no W beat is held and BVALID=0.
  - AW and W are accepted independently, in either order or in the same cycle. Each ready drops the cycle after its handshake.
  - On the edge after both beats are held, the register is updated per WSTRB. BVALID=1 on that edge, with BRESP=OKAY (2'b00).
  - Out-of-range write: no register changes; BRESP=SLVERR (2'b10).
  - BVALID and BRESP hold until BREADY. After the B handshake, AWREADY/WREADY return high on the next edge.
- Read path:
  - ARREADY=1 while RVALID=0.
  - On the edge after the AR handshake: RVALID=1 and RDATA = register contents; RRESP=OKAY.
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
  - RDATA, RRESP and RVALID are held stable until the R handshake.
- Read/write collision: a read capturing a register in the same cycle as a write commit to it returns the pre-write value.
- Read and write paths never stall each other.
- Master VALID dropped before handshake is not required to be tolerated.

Optional Feature:
AXI_COMM_ID_REG_EN:
- Defined: the highest register (index NUM_REGS-1) is read-only and returns constant 32'hA0C0_0001 with OKAY. Writes to it leave it unchanged and return BRESP=SLVERR.
- Undefined: all NUM_REGS registers are ordinary read/write.

Test Plan:
- Write 0xDEADBEEF to 0x00 (WSTRB=0xF), AW then W sequentially, BREADY=1 -> BRESP=00. Read 0x00 -> RDATA=0xDEADBEEF, RRESP=00.
- Write 0x12345678 to 0x04, read 0x04 -> 0x12345678. Read 0x00 -> still 0xDEADBEEF.
- W beat presented 3 cycles before AW, then a partial write to 0x08: 0xAABBCCDD, then 0x11223344 with WSTRB=0x5 -> read 0x08 returns 0xAA22CC44.
- BREADY and RREADY held low 5 cycles -> BVALID/RVALID, BRESP, RDATA stay stable; AWREADY/ARREADY stay 0 until the handshake.
- Write and read 0x100 (out of range) -> BRESP=10, RRESP=10, RDATA=0. No register changed.
- Assert ARESET after the AW handshake, before W -> all outputs 0. After release, read 0x00 returns 0 and a new write completes normally.

Source files
------------

// File: rtl/axi_comm_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit read/write registers, one outstanding transaction per path.
// Optional macro AXI_COMM_ID_REG_EN turns the top register into a read-only ID constant.
module axi_comm_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_COMM_ID_REG_EN
  localparam logic [IDX_W-1:0]      ID_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA0C0_0001;
`endif

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_en;

  logic                  aw_held_reg, aw_held_next, w_held_reg, w_held_next;
  logic [ADDR_WIDTH-1:0] aw_addr_reg, aw_addr_next;
  logic [DATA_WIDTH-1:0] w_data_reg, w_data_next;
  logic [3:0]            w_strb_reg, w_strb_next;
  logic                  awready_reg, awready_next, wready_reg, wready_next;
  logic                  bvalid_reg, bvalid_next;
  logic [1:0]            bresp_reg, bresp_next;
  logic                  arready_reg, arready_next, rvalid_reg, rvalid_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic                  wr_commit, wr_ok;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  assign wr_idx = aw_addr_reg[IDX_W+1:2];
  assign rd_idx = ARADDR[IDX_W+1:2];
`ifdef AXI_COMM_ID_REG_EN
  assign wr_ok = (aw_addr_reg < ADDR_LIMIT) && (wr_idx != ID_IDX);
`else
  assign wr_ok = (aw_addr_reg < ADDR_LIMIT);
`endif

  // Write path: AW and W latch independently; commit once both are held and no response is pending.
  always_comb begin
    aw_held_next = aw_held_reg;
    aw_addr_next = aw_addr_reg;
    w_held_next  = w_held_reg;
    w_data_next  = w_data_reg;
    w_strb_next  = w_strb_reg;
    bvalid_next  = bvalid_reg;
    bresp_next   = bresp_reg;
    wr_commit    = 1'b0;
    if (AWVALID && awready_reg) begin
      aw_held_next = 1'b1;
      aw_addr_next = AWADDR;
    end
    if (WVALID && wready_reg) begin
      w_held_next = 1'b1;
      w_data_next = WDATA;
      w_strb_next = WSTRB;
    end
    if (bvalid_reg) begin
      if (BREADY) bvalid_next = 1'b0;
    end else if (aw_held_reg && w_held_reg) begin
      wr_commit    = 1'b1;
      aw_held_next = 1'b0;
      w_held_next  = 1'b0;
      bvalid_next  = 1'b1;
      bresp_next   = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
    awready_next = !aw_held_next && !bvalid_next;
    wready_next  = !w_held_next && !bvalid_next;
  end

  // Read path: the register value is captured at the AR handshake, so a same-edge write is not seen.
  always_comb begin
    rvalid_next = rvalid_reg;
    rdata_next  = rdata_reg;
    rresp_next  = rresp_reg;
    if (rvalid_reg) begin
      if (RREADY) rvalid_next = 1'b0;
    end else if (ARVALID && arready_reg) begin
      rvalid_next = 1'b1;
      if (ARADDR < ADDR_LIMIT) begin
        rdata_next = regs_reg[rd_idx];
        rresp_next = RESP_OKAY;
`ifdef AXI_COMM_ID_REG_EN
        if (rd_idx == ID_IDX) rdata_next = ID_VALUE;
`endif
      end else begin
        rdata_next = '0;
        rresp_next = RESP_SLVERR;
      end
    end
    arready_next = !rvalid_next;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= '0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= '0;
    end else begin
      aw_held_reg <= aw_held_next;
      aw_addr_reg <= aw_addr_next;
      w_held_reg  <= w_held_next;
      w_data_reg  <= w_data_next;
      w_strb_reg  <= w_strb_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      rdata_reg   <= rdata_next;
      rresp_reg   <= rresp_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
      assign wr_en[gi] = wr_commit && wr_ok && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int r = 0; r < NUM_REGS; r++) regs_reg[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_en[r] && w_strb_reg[b]) regs_reg[r][8*b +: 8] <= w_data_reg[8*b +: 8];
        end
      end
    end
  end

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign ARREADY = arready_reg;
  assign RVALID  = rvalid_reg;
  assign RDATA   = rdata_reg;
  assign RRESP   = rresp_reg;
endmodule

// File: tb/tb_axi_comm_slave.sv
// Directed bench for axi_comm_slave; inputs driven and outputs sampled on the falling edge.
module tb_axi_comm_slave;
  localparam int LIMIT = 20;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  axi_comm_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] a);
    int cnt;
    cnt = 0;
    AWADDR = a; AWVALID = 1'b1;
    while (!AWREADY && cnt < LIMIT) begin @(negedge ACLK); cnt++; end
    if (cnt >= LIMIT) check("aw_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int cnt;
    cnt = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    while (!WREADY && cnt < LIMIT) begin @(negedge ACLK); cnt++; end
    if (cnt >= LIMIT) check("w_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int cnt;
    cnt = 0;
    ARADDR = a; ARVALID = 1'b1;
    while (!ARREADY && cnt < LIMIT) begin @(negedge ACLK); cnt++; end
    if (cnt >= LIMIT) check("ar_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic wait_bvalid();
    int cnt;
    cnt = 0;
    while (!BVALID && cnt < LIMIT) begin @(negedge ACLK); cnt++; end
    if (cnt >= LIMIT) check("b_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rvalid();
    int cnt;
    cnt = 0;
    while (!RVALID && cnt < LIMIT) begin @(negedge ACLK); cnt++; end
    if (cnt >= LIMIT) check("r_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: AW then W, 1: W three cycles before AW, 2: AW and W together
  task automatic write_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int mode, input logic [1:0] exp_resp);
    int cnt;
    logic [1:0] resp;
    if (mode == 0) begin
      send_aw(a); send_w(d, s);
    end else if (mode == 1) begin
      send_w(d, s); repeat (3) @(negedge ACLK); send_aw(a);
    end else begin
      cnt = 0;
      AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
      while (!(AWREADY && WREADY) && cnt < LIMIT) begin @(negedge ACLK); cnt++; end
      if (cnt >= LIMIT) check("aww_timeout", 32'd0, 32'd1);
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    wait_bvalid();
    resp = BRESP;
    @(negedge ACLK);
    $display("write %s addr=%h data=%h strb=%h mode=%0d bresp=%0d", tag, a, d, s, mode, resp);
    check({tag, "_bresp"}, {30'd0, resp}, {30'd0, exp_resp});
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  resp;
    send_ar(a);
    check({tag, "_rvalid_lat"}, {31'd0, RVALID}, 32'd1);
    wait_rvalid();
    d = RDATA; resp = RRESP;
    @(negedge ACLK);
    $display("read  %s addr=%h rdata=%h rresp=%0d", tag, a, d, resp);
    check({tag, "_rdata"}, d, exp_data);
    check({tag, "_rresp"}, {30'd0, resp}, {30'd0, exp_resp});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, {31'd0, AWREADY}, 32'd0);
    check({tag, "_wready"},  {31'd0, WREADY},  32'd0);
    check({tag, "_bvalid"},  {31'd0, BVALID},  32'd0);
    check({tag, "_bresp"},   {30'd0, BRESP},   32'd0);
    check({tag, "_arready"}, {31'd0, ARREADY}, 32'd0);
    check({tag, "_rvalid"},  {31'd0, RVALID},  32'd0);
    check({tag, "_rresp"},   {30'd0, RRESP},   32'd0);
    check({tag, "_rdata"},   RDATA,            32'd0);
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_reset_awready", {31'd0, AWREADY}, 32'd1);
    check("post_reset_wready",  {31'd0, WREADY},  32'd1);
    check("post_reset_arready", {31'd0, ARREADY}, 32'd1);

    // Basic writes/reads, with every AW/W ordering
    write_chk("w0", 32'h00, 32'hDEADBEEF, 4'hF, 0, 2'b00);
    read_chk("r0", 32'h00, 32'hDEADBEEF, 2'b00);
    write_chk("w4", 32'h04, 32'h12345678, 4'hF, 2, 2'b00);
    read_chk("r4", 32'h04, 32'h12345678, 2'b00);
    read_chk("r0b", 32'h00, 32'hDEADBEEF, 2'b00);
    read_chk("r4_lowbits", 32'h05, 32'h12345678, 2'b00);
    write_chk("w8", 32'h08, 32'hAABBCCDD, 4'hF, 1, 2'b00);
    write_chk("w8p", 32'h08, 32'h11223344, 4'h5, 0, 2'b00);
    read_chk("r8", 32'h08, 32'hAA22CC44, 2'b00);

    // Back-pressure on B: response and readies hold
    BREADY = 1'b0;
    send_aw(32'h0C); send_w(32'h0BADF00D, 4'hF);
    wait_bvalid();
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bstall_bvalid",  {31'd0, BVALID},  32'd1);
      check("bstall_bresp",   {30'd0, BRESP},   32'd0);
      check("bstall_awready", {31'd0, AWREADY}, 32'd0);
      check("bstall_wready",  {31'd0, WREADY},  32'd0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    check("bstall_release_bvalid", {31'd0, BVALID}, 32'd0);
    check("bstall_release_awready", {31'd0, AWREADY}, 32'd1);

    // Back-pressure on R
    RREADY = 1'b0;
    send_ar(32'h0C);
    wait_rvalid();
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("rstall_rvalid",  {31'd0, RVALID},  32'd1);
      check("rstall_rdata",   RDATA,            32'h0BADF00D);
      check("rstall_rresp",   {30'd0, RRESP},   32'd0);
      check("rstall_arready", {31'd0, ARREADY}, 32'd0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    check("rstall_release_rvalid", {31'd0, RVALID}, 32'd0);
    check("rstall_release_arready", {31'd0, ARREADY}, 32'd1);

    // Out of range accesses; 0x100 aliases index 0 if the range check were missing
    write_chk("w100", 32'h100, 32'hFFFFFFFF, 4'hF, 0, 2'b10);
    read_chk("r100", 32'h100, 32'h0, 2'b10);
    read_chk("r40", 32'h40, 32'h0, 2'b10);
    read_chk("rhigh", 32'h8000_0000, 32'h0, 2'b10);
    read_chk("r0_after_oor", 32'h00, 32'hDEADBEEF, 2'b00);
    read_chk("r8_after_oor", 32'h08, 32'hAA22CC44, 2'b00);

    // Top register
`ifdef AXI_COMM_ID_REG_EN
    write_chk("w3c", 32'h3C, 32'hCAFEF00D, 4'hF, 0, 2'b10);
    read_chk("r3c", 32'h3C, 32'hA0C00001, 2'b00);
`else
    write_chk("w3c", 32'h3C, 32'hCAFEF00D, 4'hF, 0, 2'b00);
    read_chk("r3c", 32'h3C, 32'hCAFEF00D, 2'b00);
`endif

    // Collision: AR handshake on the same edge as the write commit returns old data
    write_chk("w10", 32'h10, 32'h01020304, 4'hF, 0, 2'b00);
    AWADDR = 32'h10; WDATA = 32'h0A0B0C0D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h10; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("coll_bvalid", {31'd0, BVALID}, 32'd1);
    check("coll_rvalid", {31'd0, RVALID}, 32'd1);
    check("coll_rdata", RDATA, 32'h01020304);
    $display("read  coll addr=00000010 rdata=%h rresp=%0d", RDATA, RRESP);
    @(negedge ACLK);
    read_chk("r10_new", 32'h10, 32'h0A0B0C0D, 2'b00);

    // Reset between AW and W handshakes
    send_aw(32'h14);
    ARESET = 1'b1;
    @(negedge ACLK);
    check_all_zero("midreset");
    ARESET = 1'b0;
    @(negedge ACLK);
    read_chk("r0_after_reset", 32'h00, 32'h0, 2'b00);
    read_chk("r10_after_reset", 32'h10, 32'h0, 2'b00);
    write_chk("w14", 32'h14, 32'h00000077, 4'hF, 0, 2'b00);
    read_chk("r14", 32'h14, 32'h00000077, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
